axi_lite_slave_mem: RTL and testbench
=====================================

Name: axi_lite_slave_mem

Overview:
- Parametrised AXI4-Lite slave memory; successor to the write-only axi_slave.
- Adds a full read channel (AR/R), 2-bit responses with out-of-range error, and independent AW/W acceptance (either may arrive first).
- Configurable data width, word depth and base address.
- Sits behind axi_master, or any AXI4-Lite master, on the ACLK domain.

Parameters:
- DATA_W, 32: data bus width in bits; must be 32 or 64. WSTRB width is DATA_W/8.
- ADDR_W, 32: address bus width in bits.
- DEPTH, 16: number of DATA_W-bit memory words; must be a power of 2, at least 2.
- BASE_ADDR, 0: byte address of word 0; must be aligned to DEPTH*DATA_W/8.

Ports:
- ACLK  in  1  clock; all logic is rising-edge.
- ARESET  in  1  asynchronous, active-high reset.
- AWADDR  in  ADDR_W  write address.
- AWVALID  in  1  write address valid.
- AWREADY  out  1  write address ready.
- WDATA  in  DATA_W  write data.
- WSTRB  in  DATA_W/8  byte strobes; bit i enables byte i.
- WVALID  in  1  write data valid.
- WREADY  out  1  write data ready.
- BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
- BVALID  out  1  write response valid.
- BREADY  in  1  write response ready.
- ARADDR  in  ADDR_W  read address.
- ARVALID  in  1  read address valid.
- ARREADY  out  1  read address ready.
- RDATA  out  DATA_W  read data.
- RRESP  out  2  read response: 00 OKAY, 10 SLVERR.
- RVALID  out  1  read data valid.
- RREADY  in  1  read data ready.

Behaviour:
- Reset, while ARESET is high:
  - all READY and VALID outputs are 0; BRESP, RRESP and RDATA are 0.
  - aw_held and w_held flags cleared; every memory word cleared to 0.
  - Effect is immediate (asynchronous). Any partially accepted transaction is discarded.
- Address decode:
  - off = addr - BASE_ADDR; word index = off >> log2(DATA_W/8). Low byte-offset bits are ignored, so 0x05 maps to word 1.
  - In range iff addr >= BASE_ADDR and word index < DEPTH; out of range otherwise.
- Write address channel:
  - AWREADY = !ARESET && !aw_held && !BVALID.
  - On AWVALID&&AWREADY at a rising edge: latch AWADDR, set aw_held.
- Write data channel:
  - WREADY = !ARESET && !w_held && !BVALID.
  - On WVALID&&WREADY: latch WDATA and WSTRB, set w_held.
  - AW and W may complete in the same cycle or in either order, any number of cycles apart.
- Write commit, at the first rising edge where aw_held && w_held && !BVALID:
  - If in range: for each i with WSTRB[i]=1, byte i of the word is updated; other bytes keep their value. BRESP <= 00.
  - If out of range: no memory change; BRESP <= 10.
  - BVALID <= 1; both held flags cleared.
  - Minimum latency: AW and W handshaken at edge N, commit and BVALID high after edge N+1.
- Write response:
  - BVALID and BRESP stay stable until BVALID&&BREADY at a rising edge; BVALID <= 0 at that edge.
  - While BVALID is high, no new AW or W is accepted; at most one write is outstanding.
  - WSTRB=0000 to an in-range address: no byte changes, BRESP=00.
- Read channel:
  - ARREADY = !ARESET && !RVALID.
  - On ARVALID&&ARREADY at edge N: RVALID <= 1 after edge N (latency 1).
    - In range: RDATA <= memory word, RRESP <= 00.
    - Out of range: RDATA <= 0, RRESP <= 10.
  - RDATA and RRESP are held stable until RVALID&&RREADY; RVALID <= 0 at that edge.
  - Next AR accepted no earlier than the cycle after RVALID falls; one read outstanding.
- Concurrency:
  - Read and write paths are fully independent.
  - Read handshake and write commit to the same word at the same edge: the read returns the pre-write value; a later read returns the new value.
- No FIFOs; no bursts. AxPROT is not supported.

Test Plan:
(DATA_W=32, DEPTH=16, BASE_ADDR=0)
1. Write 0x04, WDATA=0x12345678, WSTRB=1111, AW and W in the same cycle -> BVALID high one cycle later, BRESP=00. Read 0x04 -> RVALID one cycle after handshake, RDATA=0x12345678, RRESP=00.
2. After reset, write 0x08, WDATA=0xAABBCCDD, WSTRB=0101 -> read 0x08 returns 0x00BB00DD. Then write 0x09 (unaligned), WDATA=0x11223344, WSTRB=1000 -> read 0x08 returns 0x11BB00DD.
3. W presented 3 cycles before AW, BREADY held low 5 cycles after BVALID -> WREADY low after W is accepted; commit follows AW; BVALID and BRESP stable for all 5 cycles; AWREADY and WREADY stay 0 until the B handshake.
4. Write 0x40, WDATA=0xDEADBEEF -> BRESP=10, all words unchanged. Read 0x40 -> RDATA=0, RRESP=10. Read 0x3C -> RRESP=00.
5. Word 0x0C holds 0x11111111; write 0x22222222 commits at the same edge as a read handshake on 0x0C -> RDATA=0x11111111; next read returns 0x22222222.
6. AW to 0x04 accepted, W not yet sent; assert ARESET for 2 cycles mid-cycle -> all outputs 0 immediately, memory 0. After release, W alone produces no BVALID; a later AW completes the write normally with BRESP=00.

Source files
------------

// File: rtl/axi_lite_slave_mem.sv
// AXI4-Lite slave backed by a small register-file memory.
// AW and W are captured independently; one write and one read may be in flight.
module axi_lite_slave_mem #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter int                DEPTH     = 16,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
   input  logic                ACLK,
   input  logic                ARESET,
   input  logic [ADDR_W-1:0]   AWADDR,
   input  logic                AWVALID,
   output logic                AWREADY,
   input  logic [DATA_W-1:0]   WDATA,
   input  logic [DATA_W/8-1:0] WSTRB,
   input  logic                WVALID,
   output logic                WREADY,
   output logic [1:0]          BRESP,
   output logic                BVALID,
   input  logic                BREADY,
   input  logic [ADDR_W-1:0]   ARADDR,
   input  logic                ARVALID,
   output logic                ARREADY,
   output logic [DATA_W-1:0]   RDATA,
   output logic [1:0]          RRESP,
   output logic                RVALID,
   input  logic                RREADY
);

   localparam int                STRB_W  = DATA_W / 8;
   localparam int                SHIFT   = $clog2(STRB_W);
   localparam int                IDX_W   = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [1:0]        OKAY    = 2'b00;
   localparam logic [1:0]        SLVERR  = 2'b10;

   function automatic logic inRange(input logic [ADDR_W-1:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) >> SHIFT) < DEPTH_A);
   endfunction

   function automatic logic [IDX_W-1:0] wordIdx(input logic [ADDR_W-1:0] a);
      return IDX_W'((a - BASE_ADDR) >> SHIFT);
   endfunction

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic              r_awHeld;
   logic              r_wHeld;
   logic [ADDR_W-1:0] r_awAddr;
   logic [DATA_W-1:0] r_wData;
   logic [STRB_W-1:0] r_wStrb;
   logic              r_bValid;
   logic [1:0]        r_bResp;
   logic              r_rValid;
   logic [DATA_W-1:0] r_rData;
   logic [1:0]        r_rResp;

   logic              w_awHs;
   logic              w_wHs;
   logic              w_arHs;
   logic              w_commit;
   logic              w_wrInRange;
   logic [IDX_W-1:0]  w_wrIdx;
   logic              w_rdInRange;
   logic [IDX_W-1:0]  w_rdIdx;

   assign AWREADY = !ARESET && !r_awHeld && !r_bValid;
   assign WREADY  = !ARESET && !r_wHeld && !r_bValid;
   assign ARREADY = !ARESET && !r_rValid;

   assign w_awHs      = AWVALID && AWREADY;
   assign w_wHs       = WVALID && WREADY;
   assign w_arHs      = ARVALID && ARREADY;
   assign w_commit    = r_awHeld && r_wHeld && !r_bValid;
   assign w_wrInRange = inRange(r_awAddr);
   assign w_wrIdx     = wordIdx(r_awAddr);
   assign w_rdInRange = inRange(ARADDR);
   assign w_rdIdx     = wordIdx(ARADDR);

   assign BVALID = r_bValid;
   assign BRESP  = r_bResp;
   assign RVALID = r_rValid;
   assign RDATA  = r_rData;
   assign RRESP  = r_rResp;

   // AW and W are latched separately; the commit fires once both are held
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_awHeld <= 1'b0;
         r_wHeld  <= 1'b0;
         r_awAddr <= '0;
         r_wData  <= '0;
         r_wStrb  <= '0;
         r_bValid <= 1'b0;
         r_bResp  <= OKAY;
      end else begin
         if (w_awHs) begin
            r_awAddr <= AWADDR;
            r_awHeld <= 1'b1;
         end
         if (w_wHs) begin
            r_wData <= WDATA;
            r_wStrb <= WSTRB;
            r_wHeld <= 1'b1;
         end
         if (w_commit) begin
            r_awHeld <= 1'b0;
            r_wHeld  <= 1'b0;
            r_bValid <= 1'b1;
            r_bResp  <= w_wrInRange ? OKAY : SLVERR;
         end else if (r_bValid && BREADY) begin
            r_bValid <= 1'b0;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else if (w_commit && w_wrInRange) begin
         for (int b = 0; b < STRB_W; b++) begin
            if (r_wStrb[b]) begin
               r_mem[w_wrIdx][b*8 +: 8] <= r_wData[b*8 +: 8];
            end
         end
      end
   end

   // Reads sample the array before any same-edge commit lands
   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         r_rValid <= 1'b0;
         r_rData  <= '0;
         r_rResp  <= OKAY;
      end else if (w_arHs) begin
         r_rValid <= 1'b1;
         r_rData  <= w_rdInRange ? r_mem[w_rdIdx] : '0;
         r_rResp  <= w_rdInRange ? OKAY : SLVERR;
      end else if (r_rValid && RREADY) begin
         r_rValid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_axi_lite_slave_mem.sv
// Scoreboard bench for axi_lite_slave_mem: stimulus pushes expected responses,
// a negedge monitor pops and compares them on each B/R handshake.
module tb_axi_lite_slave_mem;

   localparam int          DATA_W    = 32;
   localparam int          ADDR_W    = 32;
   localparam int          DEPTH     = 16;
   localparam logic [31:0] BASE_ADDR = 32'h0;

   logic        ACLK = 1'b0;
   logic        ARESET;
   logic [31:0] AWADDR;
   logic        AWVALID;
   logic        AWREADY;
   logic [31:0] WDATA;
   logic [3:0]  WSTRB;
   logic        WVALID;
   logic        WREADY;
   logic [1:0]  BRESP;
   logic        BVALID;
   logic        BREADY;
   logic [31:0] ARADDR;
   logic        ARVALID;
   logic        ARREADY;
   logic [31:0] RDATA;
   logic [1:0]  RRESP;
   logic        RVALID;
   logic        RREADY;

   int          checks   = 0;
   int          failures = 0;
   logic [1:0]  bQ [$];
   logic [33:0] rQ [$];
   logic [31:0] model [DEPTH];

   axi_lite_slave_mem #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .DEPTH    (DEPTH),
      .BASE_ADDR(BASE_ADDR)
   ) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .AWADDR (AWADDR),
      .AWVALID(AWVALID),
      .AWREADY(AWREADY),
      .WDATA  (WDATA),
      .WSTRB  (WSTRB),
      .WVALID (WVALID),
      .WREADY (WREADY),
      .BRESP  (BRESP),
      .BVALID (BVALID),
      .BREADY (BREADY),
      .ARADDR (ARADDR),
      .ARVALID(ARVALID),
      .ARREADY(ARREADY),
      .RDATA  (RDATA),
      .RRESP  (RRESP),
      .RVALID (RVALID),
      .RREADY (RREADY)
   );

   always #5 ACLK = ~ACLK;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
      end
   endtask

   // Reference memory: byte-addressed words of 4 bytes starting at BASE_ADDR
   function automatic bit refInRange(input logic [31:0] a);
      return (a >= BASE_ADDR) && (((a - BASE_ADDR) / 4) < DEPTH);
   endfunction

   function automatic logic [33:0] refRead(input logic [31:0] a);
      if (refInRange(a)) return {2'b00, model[(a - BASE_ADDR) / 4]};
      return {2'b10, 32'h0};
   endfunction

   function automatic logic [1:0] refWrite(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      if (!refInRange(a)) return 2'b10;
      idx = int'((a - BASE_ADDR) / 4);
      for (int b = 0; b < 4; b++) begin
         if (s[b]) model[idx][b*8 +: 8] = d[b*8 +: 8];
      end
      return 2'b00;
   endfunction

   task automatic clearModel();
      for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
      bQ.delete();
      rQ.delete();
   endtask

   // Response monitor: every B or R handshake must match the oldest expectation
   always @(negedge ACLK) begin
      if (!ARESET) begin
         if (BVALID && BREADY) begin
            if (bQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL bUnexpected actual BVALID=1 BRESP=%0b required no response", BRESP);
            end else begin
               checkOutput("bresp", 64'(BRESP), 64'(bQ.pop_front()));
            end
         end
         if (RVALID && RREADY) begin
            if (rQ.size() == 0) begin
               checks++;
               failures++;
               $display("[TB] FAIL rUnexpected actual RVALID=1 RDATA=0x%0h required no response", RDATA);
            end else begin
               checkOutput("rrespData", 64'({RRESP, RDATA}), 64'(rQ.pop_front()));
            end
         end
      end
   end

   task automatic applyReset();
      @(posedge ACLK);
      #1;
      ARESET  = 1'b1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      ARVALID = 1'b0;
      BREADY  = 1'b1;
      RREADY  = 1'b1;
      clearModel();
      repeat (2) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("resetReady", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b000));
      checkOutput("resetValid", 64'({BVALID, RVALID}), 64'(2'b00));
      checkOutput("resetData", 64'({BRESP, RRESP, RDATA}), 64'(0));
      @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      @(negedge ACLK);
      checkOutput("postResetReady", 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
      @(posedge ACLK);
      #1;
   endtask

   // One complete transaction with both address and data offered together
   task automatic applyStimulus(input bit isWrite, input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
      bit awDone;
      bit wDone;
      bit awHs;
      bit wHs;
      bit sameCyc;
      int got;
      awDone  = 1'b0;
      wDone   = 1'b0;
      sameCyc = 1'b0;
      got     = -1;
      if (isWrite) begin
         bQ.push_back(refWrite(addr, data, strb));
         AWADDR  = addr;
         WDATA   = data;
         WSTRB   = strb;
         AWVALID = 1'b1;
         WVALID  = 1'b1;
         for (int c = 0; c < 20 && !(awDone && wDone); c++) begin
            @(negedge ACLK);
            awHs = AWVALID && AWREADY;
            wHs  = WVALID && WREADY;
            @(posedge ACLK);
            #1;
            if (awHs && wHs) sameCyc = 1'b1;
            if (awHs) begin AWVALID = 1'b0; awDone = 1'b1; end
            if (wHs)  begin WVALID  = 1'b0; wDone  = 1'b1; end
         end
         AWVALID = 1'b0;
         WVALID  = 1'b0;
         checkOutput("wrHandshake", 64'({awDone, wDone}), 64'(2'b11));
         for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (BVALID && BREADY) got = c;
            @(posedge ACLK);
            #1;
            if (got >= 0) break;
         end
         if (sameCyc) checkOutput("bLatency", 64'(got), 64'(1));
         else         checkOutput("bSeen", 64'(got >= 0), 64'(1));
      end else begin
         rQ.push_back(refRead(addr));
         ARADDR  = addr;
         ARVALID = 1'b1;
         for (int c = 0; c < 20 && !awDone; c++) begin
            @(negedge ACLK);
            awHs = ARVALID && ARREADY;
            @(posedge ACLK);
            #1;
            if (awHs) awDone = 1'b1;
         end
         ARVALID = 1'b0;
         checkOutput("arHandshake", 64'(awDone), 64'(1));
         for (int c = 0; c < 20; c++) begin
            @(negedge ACLK);
            if (RVALID && RREADY) got = c;
            @(posedge ACLK);
            #1;
            if (got >= 0) break;
         end
         checkOutput("rLatency", 64'(got), 64'(0));
      end
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog expired actual=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      logic [31:0] d;
      logic [33:0] oldExp;
      ARESET  = 1'b1;
      AWADDR  = '0;
      AWVALID = 1'b0;
      WDATA   = '0;
      WSTRB   = '0;
      WVALID  = 1'b0;
      BREADY  = 1'b1;
      ARADDR  = '0;
      ARVALID = 1'b0;
      RREADY  = 1'b1;
      clearModel();

      applyReset();
      applyStimulus(1'b1, 32'h04, 32'h12345678, 4'hF);
      applyStimulus(1'b0, 32'h04, 32'h0, 4'h0);

      applyReset();
      applyStimulus(1'b1, 32'h08, 32'hAABBCCDD, 4'b0101);
      applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);
      applyStimulus(1'b1, 32'h09, 32'h11223344, 4'b1000);
      applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);

      // W leads AW by three cycles; B is then back-pressured for five cycles
      d = $urandom;
      bQ.push_back(refWrite(32'h10, d, 4'hF));
      WDATA  = d;
      WSTRB  = 4'hF;
      WVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t3WReady", 64'(WREADY), 64'(1));
      @(posedge ACLK);
      #1;
      WVALID = 1'b0;
      repeat (3) begin
         @(negedge ACLK);
         checkOutput("t3WaitAw", 64'({WREADY, BVALID}), 64'(2'b00));
         @(posedge ACLK);
         #1;
      end
      BREADY  = 1'b0;
      AWADDR  = 32'h10;
      AWVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t3AwReady", 64'(AWREADY), 64'(1));
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      @(negedge ACLK);
      checkOutput("t3BPre", 64'(BVALID), 64'(0));
      @(posedge ACLK);
      #1;
      repeat (5) begin
         @(negedge ACLK);
         checkOutput("t3BHold", 64'({BVALID, BRESP, AWREADY, WREADY}), 64'(5'b1_00_0_0));
         @(posedge ACLK);
         #1;
      end
      BREADY = 1'b1;
      @(posedge ACLK);
      #1;
      @(negedge ACLK);
      checkOutput("t3BDone", 64'({BVALID, AWREADY, WREADY}), 64'(3'b011));
      @(posedge ACLK);
      #1;
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);

      applyStimulus(1'b1, 32'h40, 32'hDEADBEEF, 4'hF);
      applyStimulus(1'b0, 32'h40, 32'h0, 4'h0);
      applyStimulus(1'b0, 32'h3C, 32'h0, 4'h0);
      applyStimulus(1'b0, 32'h00, 32'h0, 4'h0);
      applyStimulus(1'b0, 32'h08, 32'h0, 4'h0);

      // Write commit and read handshake land on the same edge
      applyStimulus(1'b1, 32'h0C, 32'h11111111, 4'hF);
      oldExp = refRead(32'h0C);
      bQ.push_back(refWrite(32'h0C, 32'h22222222, 4'hF));
      AWADDR  = 32'h0C;
      WDATA   = 32'h22222222;
      WSTRB   = 4'hF;
      AWVALID = 1'b1;
      WVALID  = 1'b1;
      @(negedge ACLK);
      checkOutput("t5AwW", 64'({AWREADY, WREADY}), 64'(2'b11));
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      WVALID  = 1'b0;
      rQ.push_back(oldExp);
      ARADDR  = 32'h0C;
      ARVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t5ArReady", 64'(ARREADY), 64'(1));
      @(posedge ACLK);
      #1;
      ARVALID = 1'b0;
      @(negedge ACLK);
      checkOutput("t5Both", 64'({BVALID, RVALID}), 64'(2'b11));
      @(posedge ACLK);
      #1;
      applyStimulus(1'b0, 32'h0C, 32'h0, 4'h0);

      // Mid-cycle reset discards a held AW
      AWADDR  = 32'h04;
      AWVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t6AwReady", 64'(AWREADY), 64'(1));
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      #2;
      ARESET = 1'b1;
      clearModel();
      #1;
      checkOutput("t6ResetNow", 64'({AWREADY, WREADY, ARREADY, BVALID, RVALID, BRESP, RRESP, RDATA}), 64'(0));
      repeat (2) @(posedge ACLK);
      #1;
      ARESET = 1'b0;
      applyStimulus(1'b0, 32'h10, 32'h0, 4'h0);
      applyStimulus(1'b0, 32'h04, 32'h0, 4'h0);
      d = $urandom;
      WDATA  = d;
      WSTRB  = 4'hF;
      WVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t6WReady", 64'(WREADY), 64'(1));
      @(posedge ACLK);
      #1;
      WVALID = 1'b0;
      repeat (4) begin
         @(negedge ACLK);
         checkOutput("t6NoB", 64'(BVALID), 64'(0));
         @(posedge ACLK);
         #1;
      end
      bQ.push_back(refWrite(32'h04, d, 4'hF));
      AWADDR  = 32'h04;
      AWVALID = 1'b1;
      @(negedge ACLK);
      checkOutput("t6AwLate", 64'(AWREADY), 64'(1));
      @(posedge ACLK);
      #1;
      AWVALID = 1'b0;
      @(negedge ACLK);
      checkOutput("t6BPre", 64'(BVALID), 64'(0));
      @(posedge ACLK);
      #1;
      @(negedge ACLK);
      checkOutput("t6BPost", 64'(BVALID), 64'(1));
      @(posedge ACLK);
      #1;
      applyStimulus(1'b0, 32'h04, 32'h0, 4'h0);

      // Randomized mix, including out-of-range and unaligned addresses
      for (int n = 0; n < 60; n++) begin
         applyStimulus(1'($urandom_range(0, 1)), 32'($urandom_range(0, 32'h4F)),
                       32'($urandom), 4'($urandom_range(0, 15)));
      end

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      checkOutput("bQueueEmpty", 64'(bQ.size()), 64'(0));
      checkOutput("rQueueEmpty", 64'(rQ.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
